// File: rtl/two_dir_fir_frame_ctrl.sv
// Frame sequencer for two_dir_fir: gates source pixels into the filter, pads the
// frame tail with zeros, waits for every filtered pixel to leave, then reports done.
module two_dir_fir_frame_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int COEFF_WIDTH   = 14,
  parameter int TAP_NUMS      = 3,
  parameter int SIZE_WIDTH    = 12,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [SIZE_WIDTH-1:0]    h_size_i,
  input  logic [SIZE_WIDTH-1:0]    v_size_i,
  input  logic [3*COEFF_WIDTH-1:0] coeff_v_i,
  input  logic [3*COEFF_WIDTH-1:0] coeff_h_i,
  input  logic                     src_valid_i,
  input  logic [DATA_WIDTH-1:0]    src_data_i,
  output logic                     src_ready_o,
  output logic                     fir_ce_o,
  output logic                     fir_valid_o,
  output logic [DATA_WIDTH-1:0]    fir_data_o,
  input  logic                     fir_ready_i,
  output logic [3*COEFF_WIDTH-1:0] fir_coeff_v_o,
  output logic [3*COEFF_WIDTH-1:0] fir_coeff_h_o,
  output logic [SIZE_WIDTH-1:0]    fir_h_size_o,
  output logic [SIZE_WIDTH-1:0]    fir_v_size_o,
  input  logic                     fir_valid_out_i,
  output logic                     sof_o,
  output logic                     eol_o,
  output logic                     eof_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     err_o
);
  localparam int PW = 2 * SIZE_WIDTH;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [SIZE_WIDTH-1:0] TAPS_S  = SIZE_WIDTH'(TAP_NUMS);
  localparam logic [PW-1:0]         HALF_P  = PW'(TAP_NUMS / 2);
  localparam logic [TW-1:0]         TO_LAST = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [SIZE_WIDTH-1:0]    h_sh, v_sh, x_cnt, y_cnt;
  logic [3*COEFF_WIDTH-1:0] cv_sh, ch_sh;
  logic [PW-1:0]            flush_cnt, flush_tgt, out_cnt, out_nxt, prod_q;
  logic [TW-1:0]            idle_cnt;
  logic                     err_q;
  logic                     cfg_ok, start_ok, xfer, last_x, last_y;
  logic                     out_inc, timeout, clr;

  assign cfg_ok    = (h_size_i >= TAPS_S) && (v_size_i >= TAPS_S);
  assign start_ok  = (state == IDLE) && start_i && !abort_i && cfg_ok;
  assign xfer      = (state == RUN) ? (src_valid_i & fir_ready_i)
                                    : ((state == FLUSH) & fir_ready_i);
  assign last_x    = (x_cnt == h_sh - SIZE_WIDTH'(1));
  assign last_y    = (y_cnt == v_sh - SIZE_WIDTH'(1));
  // Zero padding needed to push the last real pixel through both tap directions.
  assign flush_tgt = {{SIZE_WIDTH{1'b0}}, h_sh} * HALF_P + HALF_P;
  // Outputs beyond h*v are ignored once the frame count is reached.
  assign out_inc   = fir_valid_out_i &
                     ((state == RUN) |
                      (((state == FLUSH) | (state == DRAIN)) & (out_cnt != prod_q)));
  assign out_nxt   = out_cnt + {{(PW-1){1'b0}}, out_inc};
  assign timeout   = (state == DRAIN) && !fir_valid_out_i && (out_nxt != prod_q) &&
                     (idle_cnt == TO_LAST);
  assign clr       = (state == IDLE) || (state_nxt == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    src_ready_o  = 1'b0;
    fir_ce_o     = 1'b0;
    fir_valid_o  = 1'b0;
    fir_data_o   = '0;
    busy_o       = 1'b0;
    sof_o        = 1'b0;
    eol_o        = 1'b0;
    eof_o        = 1'b0;
    frame_done_o = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN: begin
        fir_ce_o    = 1'b1;
        busy_o      = 1'b1;
        fir_valid_o = src_valid_i;
        fir_data_o  = src_data_i;
        src_ready_o = fir_ready_i;
        sof_o       = xfer && (x_cnt == '0) && (y_cnt == '0);
        eol_o       = xfer && last_x;
        eof_o       = xfer && last_x && last_y;
        if (abort_i)    state_nxt = IDLE;
        else if (eof_o) state_nxt = FLUSH;
      end
      FLUSH: begin
        fir_ce_o    = 1'b1;
        busy_o      = 1'b1;
        fir_valid_o = 1'b1;
        if (abort_i) state_nxt = IDLE;
        else if (xfer && (flush_cnt == flush_tgt - PW'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        fir_ce_o = 1'b1;
        busy_o   = 1'b1;
        if (abort_i)                  state_nxt = IDLE;
        else if (out_nxt == prod_q)   state_nxt = DONE;
        else if (timeout)             state_nxt = IDLE;
      end
      DONE: begin
        busy_o       = 1'b1;
        frame_done_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sh      <= '0;
      v_sh      <= '0;
      cv_sh     <= '0;
      ch_sh     <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      flush_cnt <= '0;
      out_cnt   <= '0;
      prod_q    <= '0;
      idle_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= ((state == IDLE) && start_i && !abort_i && !cfg_ok) || timeout;
      prod_q <= {{SIZE_WIDTH{1'b0}}, h_sh} * {{SIZE_WIDTH{1'b0}}, v_sh};
      if (start_ok) begin
        h_sh  <= h_size_i;
        v_sh  <= v_size_i;
        cv_sh <= coeff_v_i;
        ch_sh <= coeff_h_i;
      end
      if (clr) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        flush_cnt <= '0;
        out_cnt   <= '0;
        idle_cnt  <= '0;
      end else begin
        out_cnt <= out_nxt;
        if (state == RUN && xfer) begin
          if (last_x) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + SIZE_WIDTH'(1);
          end else begin
            x_cnt <= x_cnt + SIZE_WIDTH'(1);
          end
        end
        if (state == FLUSH && xfer) flush_cnt <= flush_cnt + PW'(1);
        if (state == DRAIN) idle_cnt <= fir_valid_out_i ? '0 : idle_cnt + TW'(1);
      end
    end
  end

  assign fir_coeff_v_o = cv_sh;
  assign fir_coeff_h_o = ch_sh;
  assign fir_h_size_o  = h_sh;
  assign fir_v_size_o  = v_sh;
  assign err_o         = err_q;

endmodule
